cpu7_exu_eclscbd: RTL
=====================

CPU7_EXU_ECLSCBD -- requirements
Module: cpu7_exu_eclscbd

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2, meaning the maximum number of in-flight long-latency writebacks (range 1..7).
REQ-002 SHALL have ports:
- clk  input  1  clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_d  input  1  decode slot holds a valid instruction.
- rs1_d, rs2_d  input  5 each  decode source register indices.
- rs1_use_d, rs2_use_d  input  1 each  the source is actually read.
- rd_d  input  5  decode destination register index.
- wen_d  input  1  the decode instruction writes rd_d.
- long_d  input  1  the decode instruction is long-latency (load or div).
- flush  input  1  kills the decode instruction this cycle.
- cpl_vld  input  1  a long-latency result writes back this cycle.
- cpl_rd  input  5  the writeback destination.
- stall_d  output  1  hold decode; no issue this cycle.
- pending  output  32  the scoreboard vector.
- out_cnt  output  3  the count of in-flight long operations.
- stall_cnt  output  16  saturating count of stall cycles.
- err  output  1  sticky completion-underflow flag.

Function
REQ-003 SHALL define issue = valid_d & ~flush & ~stall_d.
REQ-004 SHALL define accept_long = issue & long_d & wen_d & (rd_d != 0).
REQ-005 SHALL set pending[rd_d] on the clock edge after accept_long.
REQ-006 SHALL clear pending[cpl_rd] on the clock edge after cpl_vld.
REQ-007 SHALL keep pending[rd] set when accept_long and cpl_vld target the same rd in the same cycle, because the younger issue wins.
REQ-008 SHALL keep pending[0] at 0 permanently, and a completion to x0 SHALL leave pending unchanged.
REQ-009 SHALL define raw1 = rs1_use_d & pending[rs1_d], and raw2 the same for rs2.
REQ-010 SHALL define waw = wen_d & pending[rd_d].
REQ-011 SHALL define full = long_d & (out_cnt == MAX_OUT) & ~cpl_vld.
REQ-012 SHALL assert stall_d = valid_d & ~flush & (raw1 | raw2 | waw | full), combinationally with zero latency.
REQ-013 SHALL apply the following out_cnt rules, with no wrap-around:
- accept_long and no cpl_vld: out_cnt increments by 1.
- cpl_vld and no accept_long: out_cnt decrements by 1.
- both in the same cycle: out_cnt is unchanged.
REQ-014 SHALL, when cpl_vld arrives with out_cnt == 0 and no accept_long, hold out_cnt at 0, leave pending unchanged, and set err until reset.
REQ-015 SHALL implement the stall FSM with states:
- RUN: stall_d is low.
- HOLD: stall_d is high.
- Transition: the FSM moves to HOLD on the cycle stall_d is high and returns to RUN on the cycle stall_d is low.
- Counting: stall_cnt increments by 1 for each cycle stall_d is high and saturates at 16'hFFFF.
REQ-016 SHALL not clear pending or out_cnt on flush, because in-flight completions still return.

Reset
REQ-017 SHALL, while reset is high, asynchronously drive pending=0, out_cnt=0, stall_cnt=0, err=0, FSM=RUN, and therefore stall_d=0.
REQ-018 SHALL, on reset asserted mid-operation, discard all outstanding state, and a completion arriving after reset deasserts SHALL trigger the REQ-014 behaviour.

Configuration
REQ-019 SHALL provide macro CPU7_SCBD_CPL_BYPASS_EN.
REQ-020 SHALL, with CPU7_SCBD_CPL_BYPASS_EN defined, suppress the raw1, raw2 and waw terms when cpl_vld is high and cpl_rd equals the matching register index, because the W-stage bypass supplies the value that cycle.
REQ-021 SHALL, with CPU7_SCBD_CPL_BYPASS_EN undefined, stall on the completion cycle, and decode SHALL proceed on the following cycle.

Structure
REQ-022 SHALL place the FSM state encoding (RUN=1'b0, HOLD=1'b1), the MAX_OUT default and the stall_cnt width in the shared decoded.vh/common.vh constants.
REQ-023 SHALL use a single sub-module, cpu7_exu_scbd_reg, which holds the 32-bit pending vector with its set/clear port pair.
REQ-024 SHALL keep the hazard, counter and FSM logic in the top module.

Verification
REQ-025 Load-use: load issues to rd=5; next cycle rs1_d=5, rs1_use_d=1 -> stall_d=1 until cpl_vld with cpl_rd=5.
- With CPU7_SCBD_CPL_BYPASS_EN: stall_d falls in the completion cycle.
- Without it: stall_d falls one cycle after completion.
REQ-026 Same-cycle set/clear: pending[7]=1, cpl_rd=7 and accept_long to rd=7 in the same cycle -> pending[7] stays 1, out_cnt unchanged.
REQ-027 Full: MAX_OUT=2, two loads outstanding, third load in decode -> stall_d=1; cpl_vld to any rd in the same cycle -> stall_d=0 and out_cnt stays 2.
REQ-028 x0 and flush:
- A load to rd=0 -> pending stays 0 and out_cnt stays 0.
- A load with flush=1 -> no set, stall_d=0.
REQ-029 Underflow/reset: cpl_vld with out_cnt=0 -> err=1 and stays set; reset asserted mid-stall with out_cnt=2 -> all outputs 0 asynchronously.
REQ-030 Saturation: hold a hazard for 70000 cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/cpu7_exu_eclscbd_pkg.sv
// Shared constants for the execute-unit register scoreboard.
// The stall FSM encoding, the in-flight limit default and the stall counter width live here.
package cpu7_exu_eclscbd_pkg;

   localparam int unsigned NumRegs       = 32;
   localparam int unsigned RegIdxW       = 5;
   localparam int unsigned OutCntW       = 3;
   localparam int unsigned MaxOutDefault = 2;
   localparam int unsigned StallCntW     = 16;

   typedef enum logic {
      StRun  = 1'b0,
      StHold = 1'b1
   } stall_state_e;

endpackage

// File: rtl/cpu7_exu_scbd_reg.sv
// Pending-writeback vector: one bit per architectural register.
// A set and a clear can hit the same index in one cycle, and the set wins.
// Bit 0 (x0) is never pending.
module cpu7_exu_scbd_reg
   import cpu7_exu_eclscbd_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               set_vld_i,
   input  logic [RegIdxW-1:0] set_idx_i,
   input  logic               clr_vld_i,
   input  logic [RegIdxW-1:0] clr_idx_i,
   output logic [NumRegs-1:0] pending_o
);

   logic [NumRegs-1:0] pend_q, pend_d;

   // Next vector: clear first, then set, so the younger issue overrides a same-index completion.
   always_comb begin
      pend_d = pend_q;
      if (clr_vld_i) pend_d[clr_idx_i] = 1'b0;
      if (set_vld_i) pend_d[set_idx_i] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // Vector storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend_q <= '0;
      else       pend_q <= pend_d;
   end

   assign pending_o = pend_q;

endmodule

// File: rtl/cpu7_exu_eclscbd.sv
// Decode-stage scoreboard: tracks in-flight long-latency writebacks and stalls decode on
// RAW/WAW hazards or when the in-flight limit is reached.
// Optional feature: define CPU7_SCBD_CPL_BYPASS_EN to let a same-cycle writeback satisfy a
// hazard through the W-stage bypass instead of stalling.
module cpu7_exu_eclscbd
   import cpu7_exu_eclscbd_pkg::*;
#(
   parameter int unsigned MAX_OUT = MaxOutDefault
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_d,
   input  logic [RegIdxW-1:0]   rs1_d,
   input  logic [RegIdxW-1:0]   rs2_d,
   input  logic                 rs1_use_d,
   input  logic                 rs2_use_d,
   input  logic [RegIdxW-1:0]   rd_d,
   input  logic                 wen_d,
   input  logic                 long_d,
   input  logic                 flush,
   input  logic                 cpl_vld,
   input  logic [RegIdxW-1:0]   cpl_rd,
   output logic                 stall_d,
   output logic [NumRegs-1:0]   pending,
   output logic [OutCntW-1:0]   out_cnt,
   output logic [StallCntW-1:0] stall_cnt,
   output logic                 err
);

   localparam logic [OutCntW-1:0] MaxOutC = OutCntW'(MAX_OUT);

   logic                 byp_rs1, byp_rs2, byp_rd;
   logic                 raw1, raw2, waw, full;
   logic                 issue, accept_long, underflow, clr_vld;
   logic [OutCntW-1:0]   out_cnt_q, out_cnt_d;
   logic                 err_q, err_d;
   logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;
   stall_state_e         state_q, state_d;

`ifdef CPU7_SCBD_CPL_BYPASS_EN
   // A writeback landing this cycle is forwarded, so its register no longer blocks decode.
   assign byp_rs1 = cpl_vld & (cpl_rd == rs1_d);
   assign byp_rs2 = cpl_vld & (cpl_rd == rs2_d);
   assign byp_rd  = cpl_vld & (cpl_rd == rd_d);
`else
   assign byp_rs1 = 1'b0;
   assign byp_rs2 = 1'b0;
   assign byp_rd  = 1'b0;
`endif

   // Hazard detection and issue qualification, zero latency.
   always_comb begin
      raw1        = rs1_use_d & pending[rs1_d] & ~byp_rs1;
      raw2        = rs2_use_d & pending[rs2_d] & ~byp_rs2;
      waw         = wen_d & pending[rd_d] & ~byp_rd;
      // A completion in the same cycle frees a slot, so the limit only bites without one.
      full        = long_d & (out_cnt_q == MaxOutC) & ~cpl_vld;
      stall_d     = valid_d & ~flush & (raw1 | raw2 | waw | full);
      issue       = valid_d & ~flush & ~stall_d;
      accept_long = issue & long_d & wen_d & (rd_d != '0);
      // A completion with nothing in flight is a protocol error and must not touch state.
      underflow   = cpl_vld & ~accept_long & (out_cnt_q == '0);
      clr_vld     = cpl_vld & ~underflow;
   end

   cpu7_exu_scbd_reg u_scbd_reg (
      .clk       (clk),
      .reset     (reset),
      .set_vld_i (accept_long),
      .set_idx_i (rd_d),
      .clr_vld_i (clr_vld),
      .clr_idx_i (cpl_rd),
      .pending_o (pending)
   );

   // In-flight counter and sticky underflow flag next state.
   always_comb begin
      out_cnt_d = out_cnt_q;
      if (accept_long && !cpl_vld)                        out_cnt_d = out_cnt_q + 3'd1;
      else if (cpl_vld && !accept_long && !underflow)     out_cnt_d = out_cnt_q - 3'd1;
      err_d = err_q | underflow;
   end

   // In-flight counter and error flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         out_cnt_q <= out_cnt_d;
         err_q     <= err_d;
      end
   end

   // Stall FSM transitions and saturating stall-cycle count.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (stall_d)  state_d = StHold;
         StHold:  if (!stall_d) state_d = StRun;
         default: state_d = StRun;
      endcase
      stall_cnt_d = stall_cnt_q;
      if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // Stall FSM state and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_cnt   = out_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign err       = err_q;

endmodule
